// File: rtl/rfe_unit.sv
// rtl/rfe_unit.sv - return-from-exception sequencer: drain, flush, redirect PC, restore user mode.
// Optional RFE_NESTED_EN: 4-deep return-address LIFO instead of a single saved register.
module rfe_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        rfe,
  input  logic        s_u,
  input  logic        exc_taken,
  input  logic [31:0] epc_in,
  input  logic        pipe_empty,
  input  logic        fetch_ready,
  output logic        stall,
  output logic        flush,
  output logic        pc_load,
  output logic [31:0] pc_target,
  output logic        s_u_set,
  output logic        priv_err,
  output logic        busy
);

  localparam logic [31:0] RESET_TARGET = 32'h0001_0000;

  typedef enum logic [1:0] {IDLE, DRAIN, FLUSH, LOAD} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_target_q, pc_target_d;
  logic        priv_err_q, priv_err_d;
  logic        consume;
  logic [31:0] ret_addr;

`ifdef RFE_NESTED_EN
  logic [31:0] stk_q [4];
  logic [31:0] stk_d [4];
  logic [2:0]  cnt_q, cnt_d;
  logic [1:0]  top_idx;

  assign top_idx  = cnt_q[1:0] - 2'd1;
  assign ret_addr = (cnt_q != 3'd0) ? stk_q[top_idx] : RESET_TARGET;

  // Pop before push so a coincident capture lands on the post-consume stack.
  always_comb begin
    stk_d = stk_q;
    cnt_d = cnt_q;
    if (consume && (cnt_q != 3'd0)) cnt_d = cnt_q - 3'd1;
    if (exc_taken) begin
      if (cnt_d == 3'd4) begin
        stk_d[0] = stk_q[1];
        stk_d[1] = stk_q[2];
        stk_d[2] = stk_q[3];
        stk_d[3] = epc_in;
      end else begin
        stk_d[cnt_d[1:0]] = epc_in;
        cnt_d = cnt_d + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= 3'd0;
      for (int i = 0; i < 4; i++) stk_q[i] <= RESET_TARGET;
    end else begin
      cnt_q <= cnt_d;
      stk_q <= stk_d;
    end
  end
`else
  logic [31:0] saved_q, saved_d;
  logic        valid_q, valid_d;

  assign ret_addr = valid_q ? saved_q : RESET_TARGET;

  always_comb begin
    saved_d = saved_q;
    valid_d = valid_q;
    if (consume) valid_d = 1'b0;
    if (exc_taken) begin
      saved_d = epc_in;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      saved_q <= RESET_TARGET;
      valid_q <= 1'b0;
    end else begin
      saved_q <= saved_d;
      valid_q <= valid_d;
    end
  end
`endif

  always_comb begin
    state_d     = state_q;
    pc_target_d = pc_target_q;
    priv_err_d  = 1'b0;
    stall       = 1'b0;
    flush       = 1'b0;
    pc_load     = 1'b0;
    case (state_q)
      IDLE: begin
        if (rfe && !exc_taken) begin
          if (s_u) priv_err_d = 1'b1;
          else     state_d    = DRAIN;
        end
      end
      DRAIN: begin
        stall = 1'b1;
        if (exc_taken)       state_d = IDLE;
        else if (pipe_empty) state_d = FLUSH;
      end
      FLUSH: begin
        stall = 1'b1;
        flush = 1'b1;
        if (exc_taken) begin
          state_d = IDLE;
        end else begin
          pc_target_d = ret_addr;
          state_d     = LOAD;
        end
      end
      LOAD: begin
        stall   = 1'b1;
        pc_load = fetch_ready && !exc_taken;
        if (exc_taken || pc_load) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      pc_target_q <= RESET_TARGET;
      priv_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_target_q <= pc_target_d;
      priv_err_q  <= priv_err_d;
    end
  end

  assign consume   = pc_load;
  assign s_u_set   = pc_load;
  assign pc_target = pc_target_q;
  assign priv_err  = priv_err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_rfe_unit.sv
// tb/tb_rfe_unit.sv - self-checking bench for rfe_unit with a return-address scoreboard.
module tb_rfe_unit;

  logic        clk = 1'b0;
  logic        reset, rfe, s_u, exc_taken, pipe_empty, fetch_ready;
  logic [31:0] epc_in;
  logic        stall, flush, pc_load, s_u_set, priv_err, busy;
  logic [31:0] pc_target;

  int checks = 0;
  int errors = 0;

  logic [31:0] model_q[$];

  rfe_unit dut (
    .clk(clk), .reset(reset), .rfe(rfe), .s_u(s_u), .exc_taken(exc_taken),
    .epc_in(epc_in), .pipe_empty(pipe_empty), .fetch_ready(fetch_ready),
    .stall(stall), .flush(flush), .pc_load(pc_load), .pc_target(pc_target),
    .s_u_set(s_u_set), .priv_err(priv_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic model_push(input logic [31:0] a);
`ifdef RFE_NESTED_EN
    if (model_q.size() == 4) void'(model_q.pop_front());
`else
    model_q.delete();
`endif
    model_q.push_back(a);
  endtask

  function automatic logic [31:0] pop_expected();
    if (model_q.size() == 0) return 32'h0001_0000;
    return model_q.pop_back();
  endfunction

  task automatic idle_inputs();
    rfe = 0; s_u = 0; exc_taken = 0; pipe_empty = 0; fetch_ready = 0; epc_in = 32'h0;
  endtask

  task automatic capture(input logic [31:0] a);
    @(negedge clk);
    idle_inputs();
    exc_taken = 1; epc_in = a;
    model_push(a);
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic run_rfe(input int drain_n, input int hold_n,
                         output int drain_stalls, output int flush_n, output int load_wait,
                         output logic got, output logic [31:0] tgt, output logic suset,
                         output logic stable);
    logic        seen_flush;
    logic [31:0] first_tgt;
    seen_flush = 0; first_tgt = 0;
    drain_stalls = 0; flush_n = 0; load_wait = 0; got = 0; tgt = 0; suset = 0; stable = 1;
    @(negedge clk);
    idle_inputs();
    rfe = 1;
    @(negedge clk);
    rfe = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      if (i > 0) @(negedge clk);
      pipe_empty  = (i >= drain_n - 1);
      fetch_ready = seen_flush && (load_wait >= hold_n);
      #1;
      if (flush) flush_n++;
      else if (stall && !seen_flush) drain_stalls++;
      if (seen_flush) begin
        if (load_wait == 0) first_tgt = pc_target;
        else if (pc_target !== first_tgt) stable = 0;
        if (pc_load) begin
          got = 1; tgt = pc_target; suset = s_u_set;
        end else begin
          load_wait++;
        end
      end
      if (flush) seen_flush = 1;
    end
  endtask

  task automatic test_reset();
    reset = 0;
    idle_inputs();
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({stall, flush, pc_load, s_u_set, priv_err, busy} !== 6'b0) begin
      errors++; $display("FAIL reset_strobes: got %b expected 000000", {stall, flush, pc_load, s_u_set, priv_err, busy});
    end
    checks++;
    if (pc_target !== 32'h0001_0000) begin
      errors++; $display("FAIL reset_target: got %h expected 00010000", pc_target);
    end
    @(negedge clk);
    reset = 1;
  endtask

  task automatic test_basic();
    int ds, fn, lw; logic got, su, st; logic [31:0] tgt, exp;
    capture(32'h0000_2040);
    run_rfe(3, 0, ds, fn, lw, got, tgt, su, st);
    exp = pop_expected();
    checks++;
    if (got !== 1'b1) begin errors++; $display("FAIL basic_load: got %b expected 1", got); end
    checks++;
    if (tgt !== exp) begin errors++; $display("FAIL basic_target: got %h expected %h", tgt, exp); end
    checks++;
    if (ds !== 3) begin errors++; $display("FAIL basic_drain_stall: got %0d expected 3", ds); end
    checks++;
    if (fn !== 1) begin errors++; $display("FAIL basic_flush: got %0d expected 1", fn); end
    checks++;
    if (su !== 1'b1) begin errors++; $display("FAIL basic_s_u_set: got %b expected 1", su); end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++;
    if ({busy, stall, pc_load} !== 3'b0) begin
      errors++; $display("FAIL basic_idle_after: got %b expected 000", {busy, stall, pc_load});
    end
  endtask

  task automatic test_user_mode();
    int pulses = 0; int loads = 0;
    @(negedge clk);
    idle_inputs();
    rfe = 1; s_u = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      idle_inputs();
      #1;
      if (priv_err) pulses++;
      if (pc_load || busy || s_u_set) loads++;
      if (i == 0) begin
        checks++;
        if (priv_err !== 1'b1) begin errors++; $display("FAIL user_priv_err_timing: got %b expected 1", priv_err); end
      end
    end
    checks++;
    if (pulses !== 1) begin errors++; $display("FAIL user_priv_err_count: got %0d expected 1", pulses); end
    checks++;
    if (loads !== 0) begin errors++; $display("FAIL user_no_activity: got %0d expected 0", loads); end
  endtask

  task automatic test_exc_priority();
    int ds, fn, lw; logic got, su, st; logic [31:0] tgt, exp;
    @(negedge clk);
    idle_inputs();
    rfe = 1; s_u = 1; exc_taken = 1; epc_in = 32'h0000_6000;
    model_push(32'h0000_6000);
    @(negedge clk);
    idle_inputs();
    #1;
    checks++;
    if ({priv_err, busy} !== 2'b00) begin
      errors++; $display("FAIL exc_priority: got %b expected 00", {priv_err, busy});
    end
    run_rfe(1, 0, ds, fn, lw, got, tgt, su, st);
    exp = pop_expected();
    checks++;
    if (!got || tgt !== exp) begin errors++; $display("FAIL exc_priority_target: got %h expected %h", tgt, exp); end
  endtask

  task automatic test_abort();
    int ds, fn, lw; logic got, su, st; logic [31:0] tgt, exp;
    @(negedge clk);
    idle_inputs();
    rfe = 1;
    @(negedge clk);
    idle_inputs();
    #1;
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL abort_in_drain: got %b expected 1", stall); end
    @(negedge clk);
    exc_taken = 1; epc_in = 32'h0000_3000;
    model_push(32'h0000_3000);
    @(negedge clk);
    idle_inputs();
    #1;
    checks++;
    if ({busy, stall, flush, pc_load} !== 4'b0) begin
      errors++; $display("FAIL abort_idle: got %b expected 0000", {busy, stall, flush, pc_load});
    end
    run_rfe(2, 0, ds, fn, lw, got, tgt, su, st);
    exp = pop_expected();
    checks++;
    if (!got || tgt !== exp) begin errors++; $display("FAIL abort_target: got %h expected %h", tgt, exp); end
  endtask

  task automatic test_backpressure();
    int ds, fn, lw; logic got, su, st; logic [31:0] tgt, exp;
    capture(32'h4444_0008);
    run_rfe(1, 5, ds, fn, lw, got, tgt, su, st);
    exp = pop_expected();
    checks++;
    if (lw !== 5) begin errors++; $display("FAIL hold_wait: got %0d expected 5", lw); end
    checks++;
    if (st !== 1'b1) begin errors++; $display("FAIL hold_stable: got %b expected 1", st); end
    checks++;
    if (!got || tgt !== exp) begin errors++; $display("FAIL hold_target: got %h expected %h", tgt, exp); end
  endtask

  task automatic test_empty_return();
    int ds, fn, lw; logic got, su, st; logic [31:0] tgt, exp;
    run_rfe(1, 0, ds, fn, lw, got, tgt, su, st);
    exp = pop_expected();
    checks++;
    if (!got || tgt !== exp) begin errors++; $display("FAIL empty_target: got %h expected %h", tgt, exp); end
  endtask

  task automatic test_nesting();
    int ds, fn, lw; logic got, su, st; logic [31:0] tgt, exp;
    capture(32'hA000_0000);
    capture(32'hB000_0004);
    capture(32'hC000_0008);
    for (int k = 0; k < 4; k++) begin
      run_rfe(1, 0, ds, fn, lw, got, tgt, su, st);
      exp = pop_expected();
      checks++;
      if (!got || tgt !== exp) begin errors++; $display("FAIL nest_target_%0d: got %h expected %h", k, tgt, exp); end
    end
    for (int k = 0; k < 5; k++) capture(32'h0000_1000 + 32'(k) * 32'h10);
    for (int k = 0; k < 5; k++) begin
      run_rfe(1, 0, ds, fn, lw, got, tgt, su, st);
      exp = pop_expected();
      checks++;
      if (!got || tgt !== exp) begin errors++; $display("FAIL overflow_target_%0d: got %h expected %h", k, tgt, exp); end
    end
  endtask

  task automatic test_reset_in_load();
    int ds, fn, lw; int bad = 0; logic got, su, st; logic [31:0] tgt, exp;
    capture(32'h0000_5000);
    @(negedge clk);
    idle_inputs();
    rfe = 1;
    @(negedge clk);
    idle_inputs();
    pipe_empty = 1;
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    #1;
    checks++;
    if ({busy, pc_load} !== 2'b10 || pc_target !== 32'h0000_5000) begin
      errors++; $display("FAIL rst_load_entry: got busy/pc_load %b target %h expected 10 00005000", {busy, pc_load}, pc_target);
    end
    reset = 0;
    model_q.delete();
    #1;
    checks++;
    if (pc_target !== 32'h0001_0000 || busy !== 1'b0) begin
      errors++; $display("FAIL rst_load_clear: got target %h busy %b expected 00010000 0", pc_target, busy);
    end
    @(negedge clk);
    reset = 1;
    fetch_ready = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      if (s_u_set || pc_load || flush || busy) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL rst_no_pulse: got %0d expected 0", bad); end
    run_rfe(1, 0, ds, fn, lw, got, tgt, su, st);
    exp = pop_expected();
    checks++;
    if (!got || tgt !== exp) begin errors++; $display("FAIL rst_invalidated: got %h expected %h", tgt, exp); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_user_mode();
    test_exc_priority();
    test_abort();
    test_backpressure();
    test_empty_return();
    test_nesting();
    test_reset_in_load();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
